// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command controller: FSM state encoding,
// command byte layout and default sizing of the register bank.
package spi_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WR_DATA,
      RD_ISSUE,
      RD_CAPT,
      RD_WAIT
   } state_t;

   // Bit of the command byte that selects write (1) or read (0).
   localparam int unsigned CMD_RW_BIT   = 7;

   // Register address width; the command byte carries at most 7 address bits.
   localparam int unsigned DEF_ADDR_W   = 7;

   // Number of implemented registers; addresses at or above this are out of range.
   localparam int unsigned DEF_NUM_REGS = 32;

endpackage

// File: rtl/spi_cmd_ctrl.sv
// Frame-level controller for the SPI byte deserializer. Gates the
// deserializer enable, realigns it between frames, and turns received bytes
// into register-bank writes and burst reads with an auto-incrementing address.
// Byte 0 of a frame is the command (bit7 = write, bits[ADDR_W-1:0] = start
// address); every later byte is write data or a read-burst dummy byte.
// ADDR_W must not exceed 7.
module spi_cmd_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_en,
   input  logic              byte_flg,
   input  logic [7:0]        byte_in,
   output logic              pkt_en,
   output logic              pkt_clr,
   output logic              reg_wr_en,
   output logic              reg_rd_en,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   input  logic [7:0]        reg_rdata,
   output logic [7:0]        tx_byte,
   output logic              tx_load,
   output logic              busy,
   output logic              frame_err,
   output logic              addr_err,
   input  logic              err_clr
);

   state_t            r_state;
   state_t            w_next_state;
   logic              r_spi_en_d;
   logic [2:0]        r_bit_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wdata;
   logic              r_wr_en;
   logic [7:0]        r_tx_byte;
   logic              r_tx_load;
   logic              r_frame_err;
   logic              r_addr_err;

   logic              w_addr_oor;
   logic              w_spi_rise;
   logic              w_frame_end;
   logic              w_frame_err_set;
   logic              w_addr_err_set;

   // The current burst address points outside the implemented bank.
   assign w_addr_oor = (32'(r_addr) >= NUM_REGS);

   // A frame starts only on a genuine low-to-high edge of spi_en.
   assign w_spi_rise = spi_en && !r_spi_en_d;

   // spi_en dropped while a frame was in progress.
   assign w_frame_end = (r_state != IDLE) && !spi_en;

   // A completed byte on the falling cycle is a clean end, not a partial byte.
   assign w_frame_err_set = w_frame_end && !byte_flg && (r_bit_cnt != 3'd0);

   assign w_addr_err_set = ((r_state == WR_DATA) && byte_flg && w_addr_oor) ||
                           ((r_state == RD_CAPT) && w_addr_oor);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      w_next_state = r_state;
      pkt_en       = 1'b0;
      pkt_clr      = 1'b0;
      reg_rd_en    = 1'b0;
      reg_addr     = r_wr_addr;

      case (r_state)
         IDLE: begin
            pkt_clr = 1'b1;
            if (w_spi_rise) begin
               w_next_state = CMD;
            end
         end
         CMD: begin
            pkt_en = spi_en;
            if (byte_flg) begin
               w_next_state = byte_in[CMD_RW_BIT] ? WR_DATA : RD_ISSUE;
            end
         end
         WR_DATA: begin
            pkt_en = spi_en;
         end
         RD_ISSUE: begin
            pkt_en       = spi_en;
            reg_rd_en    = 1'b1;
            reg_addr     = r_addr;
            w_next_state = RD_CAPT;
         end
         RD_CAPT: begin
            pkt_en       = spi_en;
            w_next_state = RD_WAIT;
         end
         RD_WAIT: begin
            pkt_en = spi_en;
            if (byte_flg) begin
               w_next_state = RD_ISSUE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase

      // End of frame overrides every other transition.
      if (w_frame_end) begin
         w_next_state = IDLE;
      end
   end

   // Edge detector, bit counter, address counter and register-bank datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         // Held high so a frame already in progress at reset release is not
         // mistaken for a new one; spi_en must go low before a frame can start.
         r_spi_en_d <= 1'b1;
         r_bit_cnt  <= 3'd0;
         r_addr     <= '0;
         r_wr_addr  <= '0;
         r_wdata    <= 8'h00;
         r_wr_en    <= 1'b0;
         r_tx_byte  <= 8'h00;
         r_tx_load  <= 1'b0;
      end else begin
         r_spi_en_d <= spi_en;
         r_wr_en    <= 1'b0;
         r_tx_load  <= 1'b0;

         // Bit position within the current byte; realigned with the
         // deserializer whenever it is cleared or delivers a byte.
         if ((r_state == IDLE) || byte_flg) begin
            r_bit_cnt <= 3'd0;
         end else if (pkt_en) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end

         case (r_state)
            CMD: begin
               if (byte_flg) begin
                  r_addr <= byte_in[ADDR_W-1:0];
               end
            end
            WR_DATA: begin
               if (byte_flg) begin
                  r_wr_en   <= !w_addr_oor;
                  r_wr_addr <= r_addr;
                  r_wdata   <= byte_in;
                  r_addr    <= r_addr + ADDR_W'(1);
               end
            end
            RD_CAPT: begin
               r_tx_byte <= w_addr_oor ? 8'h00 : reg_rdata;
               r_tx_load <= 1'b1;
               r_addr    <= r_addr + ADDR_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Sticky error flags; a set event on the same cycle as err_clr wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err <= 1'b0;
         r_addr_err  <= 1'b0;
      end else begin
         if (w_frame_err_set) begin
            r_frame_err <= 1'b1;
         end else if (err_clr) begin
            r_frame_err <= 1'b0;
         end

         if (w_addr_err_set) begin
            r_addr_err <= 1'b1;
         end else if (err_clr) begin
            r_addr_err <= 1'b0;
         end
      end
   end

   assign reg_wr_en = r_wr_en;
   assign reg_wdata = r_wdata;
   assign tx_byte   = r_tx_byte;
   assign tx_load   = r_tx_load;
   assign busy      = (r_state != IDLE);
   assign frame_err = r_frame_err;
   assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl. The bench plays the deserializer (one
// byte_flg every 8 enabled cycles) and a register bank; dut uses 32
// registers, dut_w uses 128 so the address wrap can be seen as real writes.
module tb_spi_cmd_ctrl;

   typedef struct {
      int         cyc;
      logic [6:0] addr;
      logic [7:0] val;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_en;
   logic       byte_flg;
   logic [7:0] byte_in;
   logic [7:0] reg_rdata;
   logic       err_clr;

   logic       pkt_en, pkt_clr, reg_wr_en, reg_rd_en, tx_load, busy;
   logic       frame_err, addr_err;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata, tx_byte;

   logic       w_pkt_en, w_pkt_clr, w_reg_wr_en, w_reg_rd_en, w_tx_load, w_busy;
   logic       w_frame_err, w_addr_err;
   logic [6:0] w_reg_addr;
   logic [7:0] w_reg_wdata, w_tx_byte;

   logic [7:0] mem [128];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   ev_t        wr_q[$];
   ev_t        w_wr_q[$];
   ev_t        rd_q[$];
   ev_t        tx_q[$];

   spi_cmd_ctrl #(.ADDR_W(7), .NUM_REGS(32)) dut (
      .clk(clk), .rst(rst), .spi_en(spi_en), .byte_flg(byte_flg),
      .byte_in(byte_in), .pkt_en(pkt_en), .pkt_clr(pkt_clr),
      .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .tx_byte(tx_byte),
      .tx_load(tx_load), .busy(busy), .frame_err(frame_err),
      .addr_err(addr_err), .err_clr(err_clr)
   );

   spi_cmd_ctrl #(.ADDR_W(7), .NUM_REGS(128)) dut_w (
      .clk(clk), .rst(rst), .spi_en(spi_en), .byte_flg(byte_flg),
      .byte_in(byte_in), .pkt_en(w_pkt_en), .pkt_clr(w_pkt_clr),
      .reg_wr_en(w_reg_wr_en), .reg_rd_en(w_reg_rd_en), .reg_addr(w_reg_addr),
      .reg_wdata(w_reg_wdata), .reg_rdata(reg_rdata), .tx_byte(w_tx_byte),
      .tx_load(w_tx_load), .busy(w_busy), .frame_err(w_frame_err),
      .addr_err(w_addr_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // Cycle stamp: inside the window after posedge k, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   // Register bank model: read data valid the cycle after reg_rd_en.
   always @(posedge clk) begin
      if (reg_rd_en) reg_rdata <= mem[reg_addr];
   end

   // Event logger; all comparisons happen in the directed sequence below.
   always @(negedge clk) begin
      if (reg_wr_en)   wr_q.push_back('{cyc: cyc, addr: reg_addr, val: reg_wdata});
      if (w_reg_wr_en) w_wr_q.push_back('{cyc: cyc, addr: w_reg_addr, val: w_reg_wdata});
      if (reg_rd_en)   rd_q.push_back('{cyc: cyc, addr: reg_addr, val: 8'h00});
      if (tx_load)     tx_q.push_back('{cyc: cyc, addr: 7'h00, val: tx_byte});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Seven plain bit cycles, then byte_flg with the byte on the eighth.
   task automatic send_byte(input logic [7:0] b, output int flg_cyc);
      byte_flg = 1'b0;
      repeat (7) tick();
      byte_flg = 1'b1;
      byte_in  = b;
      flg_cyc  = cyc;
      tick();
      byte_flg = 1'b0;
   endtask

   task automatic start_frame();
      spi_en = 1'b1;
      tick();
   endtask

   task automatic end_frame();
      spi_en = 1'b0;
      repeat (2) tick();
   endtask

   task automatic clear_logs();
      wr_q.delete();
      w_wr_q.delete();
      rd_q.delete();
      tx_q.delete();
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   int f0, f1, f2, f3;

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'(i + 8'h40);
      mem[3] = 8'h5C;
      mem[4] = 8'h77;
      rst = 1'b1; spi_en = 1'b0; byte_flg = 1'b0; byte_in = 8'h00;
      err_clr = 1'b0; reg_rdata = 8'h00;
      repeat (2) tick();

      // Reset state: all outputs low except pkt_clr.
      check("reset_ctrl", {pkt_en, pkt_clr, reg_wr_en, reg_rd_en, tx_load, busy, frame_err, addr_err}, 8'b0100_0000);
      check("reset_data", {reg_addr, reg_wdata, tx_byte}, 23'h0);
      rst = 1'b0;
      tick();

      // Single write: 0x85, 0xA5.
      clear_logs();
      start_frame();
      check("cmd_enable", {busy, pkt_en, pkt_clr}, 3'b110);
      send_byte(8'h85, f0);
      send_byte(8'hA5, f1);
      end_frame();
      check("wr1_count", wr_q.size(), 1);
      check("wr1_lat", wr_q[0].cyc, f1 + 1);
      check("wr1_addr", wr_q[0].addr, 7'h05);
      check("wr1_data", wr_q[0].val, 8'hA5);
      check("wr1_flags", {frame_err, addr_err}, 2'b00);
      check("wr1_idle", {busy, pkt_clr, pkt_en}, 3'b010);

      // Burst write: 5, 6, 7.
      clear_logs();
      start_frame();
      send_byte(8'h85, f0);
      send_byte(8'h11, f1);
      send_byte(8'h22, f1);
      send_byte(8'h33, f1);
      end_frame();
      check("burst_count", wr_q.size(), 3);
      check("burst0", {wr_q[0].addr, wr_q[0].val}, {7'h05, 8'h11});
      check("burst1", {wr_q[1].addr, wr_q[1].val}, {7'h06, 8'h22});
      check("burst2", {wr_q[2].addr, wr_q[2].val}, {7'h07, 8'h33});
      check("burst2_lat", wr_q[2].cyc, f1 + 1);

      // Address wrap 0x7F -> 0x00 (128-register instance writes both).
      clear_logs();
      start_frame();
      send_byte(8'hFF, f0);
      send_byte(8'h01, f1);
      send_byte(8'h02, f1);
      end_frame();
      check("wrap_count", w_wr_q.size(), 2);
      check("wrap0", {w_wr_q[0].addr, w_wr_q[0].val}, {7'h7F, 8'h01});
      check("wrap1", {w_wr_q[1].addr, w_wr_q[1].val}, {7'h00, 8'h02});
      check("wrap_oor_count", wr_q.size(), 1);
      check("wrap_oor_w", {wr_q[0].addr, wr_q[0].val}, {7'h00, 8'h02});
      check("wrap_oor_flag", addr_err, 1'b1);
      check("wrap_w_flag", w_addr_err, 1'b0);
      pulse_err_clr();
      check("wrap_clr", addr_err, 1'b0);

      // Burst read from 3, then a dummy byte reads 4; the trailing byte's
      // read is cut short by the frame end.
      clear_logs();
      start_frame();
      send_byte(8'h03, f0);
      send_byte(8'h00, f1);
      send_byte(8'h00, f2);
      end_frame();
      check("rd_count", rd_q.size(), 3);
      check("rd0_addr", rd_q[0].addr, 7'h03);
      check("rd0_lat", rd_q[0].cyc, f0 + 1);
      check("rd1_addr", rd_q[1].addr, 7'h04);
      check("tx_count", tx_q.size(), 2);
      check("tx0_data", tx_q[0].val, 8'h5C);
      check("tx0_lat", tx_q[0].cyc, f0 + 3);
      check("tx1_data", tx_q[1].val, 8'h77);
      check("tx1_lat", tx_q[1].cyc, f1 + 3);
      check("rd_flags", {frame_err, addr_err}, 2'b00);

      // Partial byte: 8 + 3 bits then spi_en drops.
      clear_logs();
      start_frame();
      send_byte(8'h81, f0);
      repeat (3) tick();
      spi_en = 1'b0;
      tick();
      check("part_err", frame_err, 1'b1);
      check("part_clr", {pkt_clr, busy}, 2'b10);
      tick();
      check("part_nowr", wr_q.size(), 0);
      pulse_err_clr();
      check("part_errclr", frame_err, 1'b0);

      // Out-of-range write 0xA8/0xFF is suppressed and flagged.
      clear_logs();
      start_frame();
      send_byte(8'hA8, f0);
      send_byte(8'hFF, f1);
      end_frame();
      check("oor_nowr", wr_q.size(), 0);
      check("oor_w_wr", w_wr_q.size(), 1);
      check("oor_flag", addr_err, 1'b1);
      pulse_err_clr();

      // Out-of-range read returns 0x00 but still loads the transmitter.
      clear_logs();
      start_frame();
      send_byte(8'h28, f0);
      send_byte(8'h00, f1);
      end_frame();
      check("oor_rd_count", tx_q.size(), 1);
      check("oor_rd_data", tx_q[0].val, 8'h00);
      check("oor_rd_lat", tx_q[0].cyc, f0 + 3);
      check("oor_rd_flag", addr_err, 1'b1);
      pulse_err_clr();

      // Reset in WR_DATA, then spi_en held high must not start a frame.
      clear_logs();
      start_frame();
      send_byte(8'h82, f0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      check("rst_ctrl", {pkt_en, pkt_clr, reg_wr_en, reg_rd_en, tx_load, busy, frame_err, addr_err}, 8'b0100_0000);
      check("rst_data", {reg_addr, reg_wdata, tx_byte}, 23'h0);
      rst = 1'b0;
      repeat (3) tick();
      check("rst_hold_idle", {busy, pkt_en}, 2'b00);
      spi_en = 1'b0;
      tick();
      start_frame();
      send_byte(8'h8A, f0);
      send_byte(8'h3C, f1);
      end_frame();
      check("post_rst_count", wr_q.size(), 1);
      check("post_rst_wr", {wr_q[0].addr, wr_q[0].val}, {7'h0A, 8'h3C});
      check("post_rst_flags", {frame_err, addr_err}, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
